rf_wport_sched: RTL and testbench
=================================

// Module: rf_wport_sched
// PURPOSE
//  Schedules the single register-file write port (A3/WD/RFWr) between the in-order
//  pipeline writeback and a long-latency unit (mult/div, load-miss) that returns out of band.
//  Buffers long-latency results in a small FIFO and tracks pending destinations in a 32-bit
//  scoreboard. Raises decode hazard stalls and a starvation stall toward the pipeline.
// PARAMETERS
//  DEPTH      2   long-latency result FIFO entries (power of 2, >=2)
//  STARVE_LIM 4   cycles a FIFO head may wait before stall_req asserts (>=1)
// PORTS
//  clk           in   1   clock; all state updates on rising edge
//  rst           in   1   synchronous reset, active low
//  wb_we         in   1   pipeline writeback valid
//  wb_addr       in   5   pipeline writeback register
//  wb_data       in   32  pipeline writeback data
//  md_valid      in   1   long-latency result valid
//  md_addr       in   5   long-latency result register
//  md_data       in   32  long-latency result data
//  md_ready      out  1   FIFO can accept; transfer when md_valid & md_ready
//  md_issue      in   1   decode issued a long-latency op (one-cycle pulse)
//  md_issue_addr in   5   its destination register
//  id_rs/id_rt   in   5   decode source registers
//  id_rd         in   5   decode destination register
//  hz_stall      out  1   decode must stall (RAW/WAW on a pending register)
//  stall_req     out  1   pipeline must inject a WB bubble (starvation relief)
//  rf_we         out  1   to RF RFWr
//  rf_a3         out  5   to RF A3
//  rf_wd         out  32  to RF WD
// BEHAVIOUR
//  Reset (rst=0 at edge): FIFO empty, busy[31:0]=0, starve counter=0, stall_req=0.
//   While rst=0: md_ready=0, rf_we=0, hz_stall=0.
//  Write port (combinational, zero latency), priority order:
//   1) wb_we & wb_addr!=0 -> rf_we=1, rf_a3=wb_addr, rf_wd=wb_data.
//   2) FIFO non-empty -> write head, pop at edge.
//   3) FIFO empty & md_valid & md_ready -> bypass md result directly (no push).
//   else rf_we=0, rf_a3=0, rf_wd=0. rf_we is never 1 with rf_a3=0.
//  FIFO: md_ready = rst & (count<DEPTH); independent of same-cycle pop (no comb path).
//   Accepted md with md_addr=0: handshake completes, result discarded, not pushed.
//   Push and pop in same cycle: count unchanged; pointers wrap modulo DEPTH.
//   Drain order strictly FIFO.
//  Scoreboard: md_issue & md_issue_addr!=0 sets busy[addr] at edge. A long-latency write
//   granted to the port (FIFO pop or bypass) clears busy[addr]. Set and clear of the
//   same register in one cycle -> set wins. busy[0] is constant 0.
//  hz_stall = rst & (busy[id_rs] | busy[id_rt] | busy[id_rd]), combinational. Stalling
//   on id_rd prevents WAW, so wb_addr never equals a busy register.
//  Starvation: counter increments each cycle FIFO non-empty and head not written. It
//   resets to 0 on any pop or when empty, and saturates at STARVE_LIM.
//   stall_req is registered: 1 from the cycle after the counter reaches STARVE_LIM
//   until the cycle after the head pops. The pipeline presents wb_we=0 in the cycle
//   after it sees stall_req=1.
//  Mid-operation reset discards FIFO contents and clears all busy bits.
// TESTING
//  Idle, md_valid=1 addr 5 data 0xA5 -> same cycle rf_we=1,a3=5,wd=0xA5; no push; busy[5] cleared.
//  wb_we every cycle (addr 3) plus md pushes to 7,8 -> md_ready=0 after 2; rf_a3=3 throughout;
//   stall_req rises STARVE_LIM+1 cycles after first push; with wb bubbles, 7 is written, then 8.
//  md_issue addr 9, then id_rs=9 -> hz_stall=1 until md result for 9 reaches rf_we; then 0.
//  Same cycle: md_issue 4 and FIFO pop of old result for 4 -> busy[4] stays 1.
//  md result addr 0 and md_issue addr 0 -> rf_we stays 0, busy stays 0, hz_stall=0 for id_rs=0.
//  rst=0 with 2 FIFO entries and busy[6]=1 -> next cycle empty, busy=0, stall_req=0, md_ready=1.

Source files
------------

// File: rtl/rf_wport_sched.sv
// Register-file write-port scheduler: arbitrates pipeline writeback against buffered
// long-latency results, tracks pending destinations, and raises hazard/starvation stalls.
module rf_wport_sched #(
   parameter int DEPTH      = 2,
   parameter int STARVE_LIM = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_we,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   input  logic        md_valid,
   input  logic [4:0]  md_addr,
   input  logic [31:0] md_data,
   output logic        md_ready,
   input  logic        md_issue,
   input  logic [4:0]  md_issue_addr,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic [4:0]  id_rd,
   output logic        hz_stall,
   output logic        stall_req,
   output logic        rf_we,
   output logic [4:0]  rf_a3,
   output logic [31:0] rf_wd
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = $clog2(STARVE_LIM + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [SW-1:0] LIM_C   = SW'(STARVE_LIM);

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } md_entry_t;

   md_entry_t        mem [DEPTH];
   md_entry_t        head;
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [CW-1:0]    count;
   logic [31:0]      busy;
   logic [31:0]      busy_next;
   logic [SW-1:0]    starve_cnt;

   logic fifo_empty;
   logic md_fire;
   logic wb_grant;
   logic pop;
   logic bypass;
   logic push;

   assign fifo_empty = (count == '0);
   assign head       = mem[rd_ptr];

   // Ready depends only on occupancy, never on a same-cycle pop, so md_valid has no
   // combinational path back to md_ready.
   assign md_ready = rst & (count < DEPTH_C);
   assign md_fire  = md_valid & md_ready;

   assign wb_grant = rst & wb_we & (wb_addr != 5'd0);
   assign pop      = rst & ~wb_grant & ~fifo_empty;
   // Results for r0 complete the handshake but are dropped, so r0 is never written.
   assign bypass   = ~wb_grant & fifo_empty & md_fire & (md_addr != 5'd0);
   assign push     = md_fire & (md_addr != 5'd0) & ~bypass;

   // NOTE: every output of a combinational block gets a default first, so no path
   // leaves a value unassigned and no latch is inferred.
   always_comb begin
      rf_we = 1'b0;
      rf_a3 = 5'd0;
      rf_wd = 32'd0;
      if (wb_grant) begin
         rf_we = 1'b1;
         rf_a3 = wb_addr;
         rf_wd = wb_data;
      end else if (pop) begin
         rf_we = 1'b1;
         rf_a3 = head.addr;
         rf_wd = head.data;
      end else if (bypass) begin
         rf_we = 1'b1;
         rf_a3 = md_addr;
         rf_wd = md_data;
      end
   end

   // NOTE: the result storage carries no reset; an entry is only ever read after it
   // has been written, and leaving it out of reset keeps it a plain register array.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= '{addr: md_addr, data: md_data};
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // A new issue to a register must survive the retirement of an older result to it.
   always_comb begin
      busy_next = busy;
      if (pop)    busy_next[head.addr] = 1'b0;
      if (bypass) busy_next[md_addr]   = 1'b0;
      if (md_issue && (md_issue_addr != 5'd0)) busy_next[md_issue_addr] = 1'b1;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst) busy <= 32'd0;
      else      busy <= busy_next;
   end

   assign hz_stall = rst & (busy[id_rs] | busy[id_rt] | busy[id_rd]);

   // The counter measures how long the head has been blocked by writeback; stall_req
   // follows it by one cycle and drops as soon as the head finally pops.
   always_ff @(posedge clk) begin
      if (!rst) begin
         starve_cnt <= '0;
         stall_req  <= 1'b0;
      end else begin
         if (fifo_empty || pop)     starve_cnt <= '0;
         else if (starve_cnt != LIM_C) starve_cnt <= starve_cnt + SW'(1);
         stall_req <= (starve_cnt == LIM_C) && !pop;
      end
   end

   a_no_r0_write: assert property (@(posedge clk) disable iff (!rst)
      rf_we |-> (rf_a3 != 5'd0));
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
      !(push && (count == DEPTH_C) && !pop));

endmodule

// File: tb/tb_rf_wport_sched.sv
// Directed bench for rf_wport_sched: stimulus queues the expected register-file writes,
// and a negedge monitor compares every rf_we beat against that queue.
module tb_rf_wport_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        md_valid;
   logic [4:0]  md_addr;
   logic [31:0] md_data;
   logic        md_ready;
   logic        md_issue;
   logic [4:0]  md_issue_addr;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic [4:0]  id_rd;
   logic        hz_stall;
   logic        stall_req;
   logic        rf_we;
   logic [4:0]  rf_a3;
   logic [31:0] rf_wd;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;
   int  n_cmp = 0;
   int  n_err = 0;

   rf_wport_sched #(.DEPTH(2), .STARVE_LIM(4)) dut (
      .clk(clk), .rst(rst),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .md_valid(md_valid), .md_addr(md_addr), .md_data(md_data), .md_ready(md_ready),
      .md_issue(md_issue), .md_issue_addr(md_issue_addr),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .hz_stall(hz_stall), .stall_req(stall_req),
      .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic exp_wr(input logic [4:0] a, input logic [31:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic clear_in();
      wb_we = 0; wb_addr = 0; wb_data = 0;
      md_valid = 0; md_addr = 0; md_data = 0;
      md_issue = 0; md_issue_addr = 0;
      id_rs = 0; id_rt = 0; id_rd = 0;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every register-file write must match the oldest expected write.
   always @(negedge clk) begin
      if (rf_we) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL rf_write: unexpected a3=%0d wd=0x%08h at %0t", rf_a3, rf_wd, $time);
         end else begin
            mon_e = exp_q.pop_front();
            if (rf_a3 !== mon_e.addr || rf_wd !== mon_e.data) begin
               n_err++;
               $display("FAIL rf_write: got a3=%0d wd=0x%08h expected a3=%0d wd=0x%08h at %0t",
                        rf_a3, rf_wd, mon_e.addr, mon_e.data, $time);
            end
         end
      end
   end

   initial begin
      rst = 1'b0;
      clear_in();
      #1;
      // Reset state
      settle();
      check("reset_md_ready", 32'(md_ready), 0);
      check("reset_hz_stall", 32'(hz_stall), 0);
      tick();
      tick();
      rst = 1'b1;
      settle();
      check("post_reset_md_ready", 32'(md_ready), 1);
      check("post_reset_stall_req", 32'(stall_req), 0);
      check("post_reset_rf_we", 32'(rf_we), 0);
      tick();

      // Bypass of an md result straight to the port
      clear_in(); md_issue = 1; md_issue_addr = 5;
      tick();
      clear_in(); md_valid = 1; md_addr = 5; md_data = 32'hA5; id_rs = 5;
      exp_wr(5, 32'hA5);
      settle();
      check("bypass_hz_before", 32'(hz_stall), 1);
      check("bypass_rf_we", 32'(rf_we), 1);
      tick();
      clear_in(); id_rs = 5;
      settle();
      check("bypass_busy_cleared", 32'(hz_stall), 0);
      check("bypass_no_push", 32'(rf_we), 0);
      tick();

      // Continuous writeback starves two buffered results until bubbles appear
      for (int c = 0; c < 10; c++) begin
         clear_in();
         if (c != 7 && c != 8) begin
            wb_we = 1; wb_addr = 3; wb_data = 32'h3000_0000 + 32'(c);
            exp_wr(3, wb_data);
         end
         if (c == 0) begin md_valid = 1; md_addr = 7; md_data = 32'h77; end
         if (c == 1) begin md_valid = 1; md_addr = 8; md_data = 32'h88; end
         if (c == 7) exp_wr(7, 32'h77);
         if (c == 8) exp_wr(8, 32'h88);
         settle();
         if (c == 2) check("starve_full_md_ready", 32'(md_ready), 0);
         if (c == 5) check("starve_stall_req_c5", 32'(stall_req), 0);
         if (c == 6) check("starve_stall_req_c6", 32'(stall_req), 1);
         if (c == 7) check("starve_stall_req_c7", 32'(stall_req), 1);
         if (c == 7) check("starve_md_ready_c7", 32'(md_ready), 0);
         if (c == 8) check("starve_stall_req_c8", 32'(stall_req), 0);
         if (c == 8) check("starve_md_ready_c8", 32'(md_ready), 1);
         tick();
      end

      // RAW/WAW hazard on a pending register until its result is written
      clear_in(); md_issue = 1; md_issue_addr = 9;
      settle();
      check("hz_same_cycle_issue", 32'(hz_stall), 0);
      tick();
      clear_in(); id_rs = 9;
      settle();
      check("hz_rs_pending", 32'(hz_stall), 1);
      tick();
      clear_in(); id_rd = 9; wb_we = 1; wb_addr = 3; wb_data = 32'h3333;
      md_valid = 1; md_addr = 9; md_data = 32'h9999;
      exp_wr(3, 32'h3333);
      settle();
      check("hz_rd_pending", 32'(hz_stall), 1);
      tick();
      clear_in(); id_rt = 9;
      exp_wr(9, 32'h9999);
      settle();
      check("hz_rt_during_pop", 32'(hz_stall), 1);
      tick();
      clear_in(); id_rt = 9;
      settle();
      check("hz_rt_released", 32'(hz_stall), 0);
      tick();

      // Set wins over a same-cycle clear of the same register
      clear_in(); md_issue = 1; md_issue_addr = 4;
      tick();
      clear_in(); wb_we = 1; wb_addr = 3; wb_data = 32'h3444;
      md_valid = 1; md_addr = 4; md_data = 32'h44;
      exp_wr(3, 32'h3444);
      tick();
      clear_in(); md_issue = 1; md_issue_addr = 4;
      exp_wr(4, 32'h44);
      tick();
      clear_in(); id_rs = 4;
      settle();
      check("set_wins_busy4", 32'(hz_stall), 1);
      tick();
      clear_in(); id_rs = 4; md_valid = 1; md_addr = 4; md_data = 32'h4444;
      exp_wr(4, 32'h4444);
      tick();
      clear_in(); id_rs = 4;
      settle();
      check("set_wins_cleared", 32'(hz_stall), 0);
      tick();

      // Register 0 is never written or tracked
      clear_in(); md_valid = 1; md_addr = 0; md_data = 32'hDEAD; md_issue = 1; md_issue_addr = 0;
      settle();
      check("r0_md_ready", 32'(md_ready), 1);
      check("r0_rf_we", 32'(rf_we), 0);
      check("r0_hz_same", 32'(hz_stall), 0);
      tick();
      clear_in(); wb_we = 1; wb_addr = 0; wb_data = 32'h123;
      settle();
      check("r0_wb_rf_we", 32'(rf_we), 0);
      check("r0_hz_next", 32'(hz_stall), 0);
      tick();

      // Mid-operation reset with a full FIFO and a pending register
      clear_in(); md_issue = 1; md_issue_addr = 6;
      tick();
      clear_in(); wb_we = 1; wb_addr = 3; wb_data = 32'h3A00;
      md_valid = 1; md_addr = 10; md_data = 32'hA0;
      exp_wr(3, 32'h3A00);
      tick();
      clear_in(); wb_we = 1; wb_addr = 3; wb_data = 32'h3B00;
      md_valid = 1; md_addr = 11; md_data = 32'hB0;
      exp_wr(3, 32'h3B00);
      tick();
      clear_in(); rst = 1'b0; id_rs = 6;
      settle();
      check("rst_mid_md_ready", 32'(md_ready), 0);
      check("rst_mid_hz_stall", 32'(hz_stall), 0);
      check("rst_mid_rf_we", 32'(rf_we), 0);
      tick();
      clear_in(); rst = 1'b1; id_rs = 6;
      settle();
      check("rst_after_rf_we", 32'(rf_we), 0);
      check("rst_after_md_ready", 32'(md_ready), 1);
      check("rst_after_stall_req", 32'(stall_req), 0);
      check("rst_after_busy6", 32'(hz_stall), 0);
      tick();

      clear_in();
      tick();
      tick();
      check("expected_writes_left", 32'(exp_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
